// File: rtl/mips_pkg.sv
// Shared MIPS encodings, decode record and immediate-kind helpers for the decode stage.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpBgtz  = 6'h07;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpMul   = 6'h1c;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLbu   = 6'h24;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv  = 6'h06;
  localparam logic [5:0] FnSrav  = 6'h07;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnJalr  = 6'h09;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;
  localparam logic [5:0] FnSlt   = 6'h2a;
  localparam logic [5:0] FnSltu  = 6'h2b;
  localparam logic [5:0] FnMul   = 6'h02;

  typedef enum logic [2:0] {ImmSext, ImmZext, ImmLui, ImmBr, ImmJmp, ImmNone} imm_kind_e;

  // Fields stay at their instruction-encoding widths; the top resizes indices to REG_WIDTH.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [4:0] sa;
    logic [5:0] func;
    logic [5:0] alu_op;
    logic       writes_reg;
    logic       illegal;
  } decode_rec_t;

  function automatic imm_kind_e imm_kind(input logic [5:0] op);
    case (op)
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpLw, OpSw, OpLb, OpLbu, OpSb: return ImmSext;
      OpOri, OpXori:                                                   return ImmZext;
      OpLui:                                                           return ImmLui;
      OpBeq, OpBne, OpBgtz:                                            return ImmBr;
      OpJ, OpJal:                                                      return ImmJmp;
      default:                                                         return ImmNone;
    endcase
  endfunction

  function automatic logic rfunc_writes(input logic [5:0] fn);
    case (fn)
      FnAdd, FnAddu, FnSub, FnSubu, FnSlt, FnSltu, FnAnd, FnOr, FnXor, FnNor,
      FnSll, FnSllv, FnSrl, FnSrlv, FnSra, FnSrav, FnMfhi, FnMflo, FnJalr: return 1'b1;
      default:                                                            return 1'b0;
    endcase
  endfunction

  function automatic logic rfunc_legal(input logic [5:0] fn);
    case (fn)
      FnJr, FnMult, FnMultu, FnDiv, FnDivu: return 1'b1;
      default:                              return rfunc_writes(fn);
    endcase
  endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Fetch/execute handshake, decode record and writeback bus of the decode stage.
interface decode_pipe_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_WIDTH = 5
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          insn;
  logic [WIDTH-1:0]     pc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [5:0]           opcode_out;
  logic [REG_WIDTH-1:0] rs_out;
  logic [REG_WIDTH-1:0] rt_out;
  logic [REG_WIDTH-1:0] dst_out;
  logic [4:0]           sa_out;
  logic [5:0]           func_out;
  logic [5:0]           alu_op;
  logic [WIDTH-1:0]     imm_out;
  logic [WIDTH-1:0]     rs_val;
  logic [WIDTH-1:0]     rt_val;
  logic                 writes_reg;
  logic                 illegal_out;
  logic [WIDTH-1:0]     pc_out;
  logic [31:0]          insn_out;
  logic                 we_regfile;
  logic [REG_WIDTH-1:0] waddr_regfile;
  logic [WIDTH-1:0]     dval_regfile;

  modport master (
    output in_valid, insn, pc, flush, out_ready, we_regfile, waddr_regfile, dval_regfile,
    input  in_ready, out_valid, opcode_out, rs_out, rt_out, dst_out, sa_out, func_out, alu_op,
    input  imm_out, rs_val, rt_val, writes_reg, illegal_out, pc_out, insn_out
  );

  modport slave (
    input  in_valid, insn, pc, flush, out_ready, we_regfile, waddr_regfile, dval_regfile,
    output in_ready, out_valid, opcode_out, rs_out, rt_out, dst_out, sa_out, func_out, alu_op,
    output imm_out, rs_val, rt_val, writes_reg, illegal_out, pc_out, insn_out
  );
endinterface

// File: rtl/regfile_fwd.sv
// Register file with r0 tied to zero, two combinational read ports and writeback forwarding
// for both the capture reads and the operand values of a held record.
module regfile_fwd #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_WIDTH = 5,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [REG_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [REG_WIDTH-1:0] raddr_a_i,
  input  logic [REG_WIDTH-1:0] raddr_b_i,
  output logic [WIDTH-1:0]     rdata_a_o,
  output logic [WIDTH-1:0]     rdata_b_o,
  input  logic [REG_WIDTH-1:0] hold_addr_a_i,
  input  logic [REG_WIDTH-1:0] hold_addr_b_i,
  input  logic [WIDTH-1:0]     hold_data_a_i,
  input  logic [WIDTH-1:0]     hold_data_b_i,
  output logic [WIDTH-1:0]     hold_data_a_o,
  output logic [WIDTH-1:0]     hold_data_b_o
);
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             wr_en;
  logic             hit_a, hit_b, hold_hit_a, hold_hit_b;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // wr_en already excludes r0, so a hit never targets the zero register.
  assign hit_a      = BYPASS && wr_en && (waddr_i == raddr_a_i);
  assign hit_b      = BYPASS && wr_en && (waddr_i == raddr_b_i);
  assign hold_hit_a = BYPASS && wr_en && (waddr_i == hold_addr_a_i);
  assign hold_hit_b = BYPASS && wr_en && (waddr_i == hold_addr_b_i);

  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != '0) rdata_a_o = hit_a ? wdata_i : regs_q[raddr_a_i];
    if (raddr_b_i != '0) rdata_b_o = hit_b ? wdata_i : regs_q[raddr_b_i];
  end

  assign hold_data_a_o = hold_hit_a ? wdata_i : hold_data_a_i;
  assign hold_data_b_o = hold_hit_b ? wdata_i : hold_data_b_i;

endmodule

// File: rtl/decode_pipe.sv
// MIPS decode stage: one instruction per cycle into a registered record with valid/ready,
// flush, an internal register file and writeback forwarding.
module decode_pipe
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_WIDTH = 5,
  parameter bit          BYPASS    = 1'b1
) (
  input logic          clock,
  input logic          reset_n,
  decode_pipe_if.slave bus
);
  logic [31:0]          insn, insn_q;
  logic [5:0]           op, fn;
  logic                 r_fmt, legal, wr;
  logic [4:0]           dst;
  decode_rec_t          rec_d, rec_q;
  logic [WIDTH-1:0]     sext16, imm_d, imm_q, pc_q;
  logic [WIDTH-1:0]     rd_a, rd_b, hold_a, hold_b;
  logic [WIDTH-1:0]     rs_val_d, rs_val_q, rt_val_d, rt_val_q;
  logic [3:0]           jmp_hi;
  logic                 out_valid_d, out_valid_q, capture, held;

  assign insn    = bus.insn;
  assign op      = insn[31:26];
  assign fn      = insn[5:0];
  assign r_fmt   = (op == OpRtype) || (op == OpMul);
  assign capture = bus.in_valid && bus.in_ready && !bus.flush;
  assign held    = out_valid_q && !bus.out_ready;

  always_comb begin
    legal = 1'b0;
    wr    = 1'b0;
    dst   = '0;
    if (op == OpRtype) begin
      dst   = insn[15:11];
      legal = rfunc_legal(fn);
      wr    = rfunc_writes(fn);
    end else if (op == OpMul) begin
      dst   = insn[15:11];
      legal = (fn == FnMul);
      wr    = legal;
    end else begin
      case (op)
        OpAddi, OpAddiu, OpSlti, OpSltiu, OpOri, OpXori, OpLw, OpLb, OpLbu, OpLui: begin
          dst   = insn[20:16];
          legal = 1'b1;
          wr    = 1'b1;
        end
        OpSw, OpSb, OpBeq, OpBne, OpBgtz, OpJ: legal = 1'b1;
        OpJal: begin
          dst   = 5'd31;
          legal = 1'b1;
          wr    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rec_d            = '0;
    rec_d.opcode     = op;
    rec_d.rs         = insn[25:21];
    rec_d.rt         = insn[20:16];
    rec_d.dst        = dst;
    rec_d.sa         = insn[10:6];
    rec_d.func       = r_fmt ? fn : 6'h0;
    rec_d.alu_op     = r_fmt ? fn : op;
    rec_d.writes_reg = wr && legal && (dst != '0);
    rec_d.illegal    = !legal;
  end

  assign sext16 = {{(WIDTH-16){insn[15]}}, insn[15:0]};
  // Upper nibble of pc+4 without building the full sum.
  assign jmp_hi = bus.pc[31:28] + {3'b000, &bus.pc[27:2]};

  always_comb begin
    imm_d = '0;
    case (imm_kind(op))
      ImmSext: imm_d = sext16;
      ImmZext: imm_d = WIDTH'(insn[15:0]);
      ImmLui:  imm_d = WIDTH'({insn[15:0], 16'h0000});
      ImmBr:   imm_d = {sext16[WIDTH-3:0], 2'b00};
      ImmJmp:  imm_d = WIDTH'({jmp_hi, insn[25:0], 2'b00});
      default: imm_d = '0;
    endcase
  end

  regfile_fwd #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .REG_WIDTH(REG_WIDTH),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .we_i         (bus.we_regfile),
    .waddr_i      (bus.waddr_regfile),
    .wdata_i      (bus.dval_regfile),
    .raddr_a_i    (REG_WIDTH'(rec_d.rs)),
    .raddr_b_i    (REG_WIDTH'(rec_d.rt)),
    .rdata_a_o    (rd_a),
    .rdata_b_o    (rd_b),
    .hold_addr_a_i(REG_WIDTH'(rec_q.rs)),
    .hold_addr_b_i(REG_WIDTH'(rec_q.rt)),
    .hold_data_a_i(rs_val_q),
    .hold_data_b_i(rt_val_q),
    .hold_data_a_o(hold_a),
    .hold_data_b_o(hold_b)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush)          out_valid_d = 1'b0;
    else if (capture)       out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  always_comb begin
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    if (capture) begin
      rs_val_d = rd_a;
      rt_val_d = rd_b;
    end else if (held) begin
      rs_val_d = hold_a;
      rt_val_d = hold_b;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      rec_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      insn_q      <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      if (capture) begin
        rec_q  <= rec_d;
        imm_q  <= imm_d;
        pc_q   <= bus.pc;
        insn_q <= insn;
      end
    end
  end

  assign bus.in_ready    = !out_valid_q || bus.out_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.opcode_out  = rec_q.opcode;
  assign bus.rs_out      = REG_WIDTH'(rec_q.rs);
  assign bus.rt_out      = REG_WIDTH'(rec_q.rt);
  assign bus.dst_out     = REG_WIDTH'(rec_q.dst);
  assign bus.sa_out      = rec_q.sa;
  assign bus.func_out    = rec_q.func;
  assign bus.alu_op      = rec_q.alu_op;
  assign bus.writes_reg  = rec_q.writes_reg;
  assign bus.illegal_out = rec_q.illegal;
  assign bus.imm_out     = imm_q;
  assign bus.rs_val      = rs_val_q;
  assign bus.rt_val      = rt_val_q;
  assign bus.pc_out      = pc_q;
  assign bus.insn_out    = insn_q;

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the PD decode stage.
- Decodes one MIPS instruction per cycle into a registered decode record with fields, an extended immediate, a resolved destination and operand values.
- Adds a valid/ready handshake to fetch and execute, a flush input, reset, and an internal register file with r0 hardwired to zero.
- Forwards same-cycle writeback data into both the capture path and a stalled output record.

Parameters:
- WIDTH, 32: datapath/register width; must be >= 32.
- NUM_REGS, 32: number of architectural registers; power of two.
- REG_WIDTH, 5: register index width, equal to log2(NUM_REGS).
- BYPASS, 1: 1 enables writeback-to-decode forwarding; 0 makes reads see only the stored array.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents insn/pc
- in_ready  out  1  decode can accept this cycle
- insn  in  32  instruction word
- pc  in  WIDTH  instruction address
- flush  in  1  discard held record and any capture this cycle
- out_valid  out  1  decode record valid
- out_ready  in  1  execute accepts record
- opcode_out  out  6  opcode; R-type and MUL report 0 or 6'b011100 respectively
- rs_out, rt_out  out  REG_WIDTH  source indices
- dst_out  out  REG_WIDTH  destination: rd (R-type), rt (I-type ALU/load/LUI), 31 (JAL), 0 otherwise
- sa_out  out  5  insn[10:6]
- func_out  out  6  insn[5:0] for R-type, else 0
- alu_op  out  6  func for R-type/MUL, opcode otherwise
- imm_out  out  WIDTH  extended immediate
- rs_val, rt_val  out  WIDTH  operand values
- writes_reg  out  1  instruction writes dst_out (0 if dst is r0)
- illegal_out  out  1  unrecognised opcode/func
- pc_out  out  WIDTH  captured pc
- insn_out  out  32  captured insn
- we_regfile  in  1  writeback enable
- waddr_regfile  in  REG_WIDTH  writeback index
- dval_regfile  in  WIDTH  writeback data

Behaviour:
- Reset, asynchronous on reset_n low: out_valid=0; all record outputs 0; all register-file entries 0. Release is synchronous to clock.
- in_ready = !out_valid || out_ready. It is combinational and not gated by flush.
- Capture happens on a rising edge when in_valid && in_ready && !flush. Latency is 1 cycle: out_valid is 1 on the following cycle.
- On a rising edge with no capture, out_valid clears if out_ready was 1 or flush was 1; otherwise it holds.
- While out_valid && !out_ready, every record output holds stable, except the rs_val/rt_val forwarding case below.
- flush has priority over capture. With flush=1, out_valid is 0 next cycle regardless of in_valid and out_ready.
- Register file:
  - Synchronous write on the rising edge when we_regfile && waddr_regfile!=0.
  - Writes to r0 are ignored; reading r0 always returns 0.
  - Combinational read.
- Capture-path forwarding (BYPASS=1): if we_regfile && waddr_regfile!=0 && waddr_regfile==rs index, the captured rs_val is dval_regfile. The same rule applies to rt.
- Stalled-record forwarding (BYPASS=1): while a record is held, a writeback matching held rs_out/rt_out (nonzero) updates rs_val/rt_val on that edge.
- Immediate extension:
  - Sign-extend insn[15:0]: ADDI, ADDIU, SLTI, SLTIU, LW, SW, LB, LBU, SB.
  - Zero-extend insn[15:0]: ORI, XORI.
  - LUI: {insn[15:0],16'b0}, extended to WIDTH.
  - BEQ, BNE, BGTZ: sign-extend(insn[15:0])<<2.
  - J, JAL: {(pc+4)[31:28], insn[25:0], 2'b00}.
  - R-type: 0.
- Decode classes:
  - Recognised R-type func set: ADD, ADDU, SUB, SUBU, MULT, MULTU, DIV, DIVU, MFHI, MFLO, SLT, SLTU, SLL, SLLV, SRL, SRLV, SRA, SRAV, AND, OR, XOR, NOR, JR, JALR.
  - MUL: opcode 6'b011100 with func 6'b000010.
  - Recognised I-type opcode set: ADDI, ADDIU, SLTI, SLTIU, ORI, XORI, LW, SW, LB, LUI, SB, LBU, BEQ, BNE, BGTZ.
  - Recognised J-type opcode set: J, JAL.
- writes_reg = 1 only for these classes, and only when dst_out!=0:
  - R-type ALU, shift, MFHI/MFLO, MUL, JALR.
  - I-type ALU, loads, LUI.
  - JAL.
- Stores, branches, J, JR, MULT/DIV and the all-zero NOP decode with writes_reg=0. NOP has illegal_out=0.
- Anything unlisted decodes with illegal_out=1, writes_reg=0 and all other fields still decoded raw. It is still passed downstream.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and func localparams (RTYPE, MUL_OP, MUL_FUNC, ADDI…BGTZ, J, JAL);
  - the decode-record struct typedef;
  - the imm-kind enum (SEXT, ZEXT, LUI, BR, JMP, NONE).
- Sub-module regfile_fwd holds the array, the r0 rule, two combinational read ports, the write port and the forwarding muxes.
- Decode logic stays in decode_pipe.

Test Plan:
- Reset state: after reset_n pulse, out_valid=0, in_ready=1, and reads of r1..r31 via ADD instructions show rs_val=rt_val=0.
- Capture and bypass: with r1=5 written earlier, issue ADDI r2,r1,-4 (0x2022FFFC) → next cycle out_valid=1, rs_val=5, imm_out=0xFFFFFFFC, dst_out=2, writes_reg=1. Same-cycle writeback r1=9 while capturing → rs_val=9.
- Backpressure: out_ready=0 for 3 cycles → in_ready=0 and the record is stable. A writeback to held rt during the stall updates rt_val. Raising out_ready accepts the record and a new insn in the same cycle.
- Flush: assert flush with in_valid=1 and the record held → next cycle out_valid=0 and the new insn is discarded.
- Extension and jumps:
  - ORI 0x3423_8000 → imm_out=0x00008000.
  - LUI 0x3C01_1234 → imm_out=0x12340000.
  - JAL 0x0C00_0010 at pc=0x00400000 → imm_out=0x00000040, dst_out=31, writes_reg=1.
- r0 and illegal: write r0=0xFFFF then read it → rs_val=0. Opcode 6'b111111 → illegal_out=1, writes_reg=0.
